// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared types and saturating arithmetic for the PWM ramp sequencer slice.
package pwm_seq_pkg;

  localparam int W_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RAMP_UP     = 3'd1,
    RAMP_DOWN_T = 3'd2,
    HOLD        = 3'd3,
    STOPPING    = 3'd4
  } seq_state_t;

  typedef logic [W_DEFAULT-1:0] val_t;

  // min(a + b, lim), summed one bit wider so a large step can never wrap
  function automatic val_t satAddMin(input val_t a, input val_t b, input val_t lim);
    logic [W_DEFAULT:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[W_DEFAULT-1:0];
  endfunction

  function automatic val_t satSubMax(input val_t a, input val_t b, input val_t lim);
    return ((a < b) || ((a - b) < lim)) ? lim : (a - b);
  endfunction

  function automatic val_t minVal(input val_t a, input val_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/pwm_ramp_sequencer_if.sv
// Ramp command channel: valid/ready handshake carrying period, target and step.
interface pwm_ramp_sequencer_if #(parameter int W = pwm_seq_pkg::W_DEFAULT);

  logic         Cmd_Valid_In;
  logic         Cmd_Ready_Out;
  logic [W-1:0] Cmd_Period_In;
  logic [W-1:0] Cmd_Target_In;
  logic [W-1:0] Cmd_Step_In;

  modport master (
    output Cmd_Valid_In, Cmd_Period_In, Cmd_Target_In, Cmd_Step_In,
    input  Cmd_Ready_Out
  );

  modport slave (
    input  Cmd_Valid_In, Cmd_Period_In, Cmd_Target_In, Cmd_Step_In,
    output Cmd_Ready_Out
  );

endinterface

// File: rtl/pwm_ramp_sequencer_period_tracker.sv
// Mirrors the generator's period counter so duty changes land exactly on period boundaries.
module pwm_period_tracker
  import pwm_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         Clk_In,
  input  logic         Reset_In,
  input  logic         Enable_In,
  input  logic [W-1:0] Period_In,
  output logic         Boundary_Out
);

  logic [W-1:0] r_cnt;

  // Counts 0..Period inclusive, so one period spans Period+1 clocks
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_cnt <= '0;
    end else if (!Enable_In || (r_cnt == Period_In)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign Boundary_Out = Enable_In && (r_cnt == Period_In);

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Soft-start / soft-stop front end for one PWM channel: accepts ramp commands and
// walks the duty toward the target one step per PWM period.
module pwm_ramp_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                 Clk_In,
  input  logic                 Reset_In,
  pwm_ramp_sequencer_if.slave  cmdIf,
  input  logic                 Stop_In,
  output logic                 PWM_Enable_Out,
  output logic [W-1:0]         PWM_Period_Out,
  output logic [W-1:0]         PWM_Duty_Out,
  output logic                 Busy_Out,
  output logic                 At_Target_Out,
  output logic                 Done_Out,
  output logic                 Err_Out
);

  seq_state_t   r_state, w_nextState;
  logic [W-1:0] r_duty, r_period, r_target, r_step;
  logic [W-1:0] w_nextDuty, w_nextPeriod, w_nextTarget, w_nextStep;
  logic         r_enable, r_done, r_err;
  logic         w_nextEnable, w_nextDone, w_nextErr;
  logic         w_boundary, w_ready, w_accept, w_stopDone;
  logic [W-1:0] w_clampT, w_rampUp, w_rampDown;

  pwm_period_tracker #(.W(W)) u_tracker (
    .Clk_In       (Clk_In),
    .Reset_In     (Reset_In),
    .Enable_In    (r_enable),
    .Period_In    (r_period),
    .Boundary_Out (w_boundary)
  );

  // A zero step means jump straight to the target on the next boundary
  assign w_clampT   = minVal(cmdIf.Cmd_Target_In, cmdIf.Cmd_Period_In);
  assign w_rampUp   = (r_step == '0) ? r_target : satAddMin(r_duty, r_step, r_target);
  assign w_rampDown = (r_step == '0) ? r_target : satSubMax(r_duty, r_step, r_target);
  assign w_stopDone = (r_duty <= r_step) || (r_step == '0);
  assign w_accept   = cmdIf.Cmd_Valid_In && w_ready;

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextDuty   = r_duty;
    w_nextPeriod = r_period;
    w_nextTarget = r_target;
    w_nextStep   = r_step;
    w_nextEnable = r_enable;
    w_nextDone   = 1'b0;
    w_nextErr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (cmdIf.Cmd_Period_In == '0) begin
            w_nextErr = 1'b1;
          end else begin
            w_nextPeriod = cmdIf.Cmd_Period_In;
            w_nextDuty   = '0;
            w_nextEnable = 1'b1;
            w_nextTarget = w_clampT;
            w_nextStep   = cmdIf.Cmd_Step_In;
            w_nextState  = RAMP_UP;
          end
        end
      end
      RAMP_UP: begin
        if (Stop_In) begin
          w_nextState = STOPPING;
        end else if (w_boundary) begin
          w_nextDuty = w_rampUp;
          if (w_rampUp == r_target) w_nextState = HOLD;
        end
      end
      RAMP_DOWN_T: begin
        if (Stop_In) begin
          w_nextState = STOPPING;
        end else if (w_boundary) begin
          w_nextDuty = w_rampDown;
          if (w_rampDown == r_target) w_nextState = HOLD;
        end
      end
      HOLD: begin
        // The period may only change by passing through IDLE
        if (Stop_In) begin
          w_nextState = STOPPING;
        end else if (w_accept) begin
          if (cmdIf.Cmd_Period_In != r_period) begin
            w_nextErr = 1'b1;
          end else begin
            w_nextTarget = w_clampT;
            w_nextStep   = cmdIf.Cmd_Step_In;
            if (w_clampT > r_duty) begin
              w_nextState = RAMP_UP;
            end else if (w_clampT < r_duty) begin
              w_nextState = RAMP_DOWN_T;
            end
          end
        end
      end
      STOPPING: begin
        if (w_boundary) begin
          if (w_stopDone) begin
            w_nextDuty   = '0;
            w_nextEnable = 1'b0;
            w_nextDone   = 1'b1;
            w_nextState  = IDLE;
          end else begin
            w_nextDuty = r_duty - r_step;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_duty   <= '0;
      r_period <= '0;
      r_target <= '0;
      r_step   <= '0;
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_duty   <= w_nextDuty;
      r_period <= w_nextPeriod;
      r_target <= w_nextTarget;
      r_step   <= w_nextStep;
      r_enable <= w_nextEnable;
      r_done   <= w_nextDone;
      r_err    <= w_nextErr;
    end
  end

  // Ready is deliberately independent of Valid; a pending stop blocks new commands
  always_comb begin
    w_ready       = ((r_state == IDLE) || (r_state == HOLD)) && !Stop_In;
    Busy_Out      = (r_state != IDLE);
    At_Target_Out = (r_state == HOLD);
  end

  assign cmdIf.Cmd_Ready_Out = w_ready;
  assign PWM_Enable_Out      = r_enable;
  assign PWM_Period_Out      = r_period;
  assign PWM_Duty_Out        = r_duty;
  assign Done_Out            = r_done;
  assign Err_Out             = r_err;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench: table of IDLE commands, hand-written ramp/stop/reset sequences,
// and randomized ramps checked against a boundary-sequence reference model.
module tb_pwm_ramp_sequencer;

  logic        clk;
  logic        rst;
  logic        stop;
  logic        enable, busy, atTarget, done, err;
  logic [31:0] period, duty;

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;
  int accEdge = 0;
  int curP    = 0;
  int prevDuty = 0;
  int expSeq[$];

  typedef struct {
    int p; int tgt; int st;
    bit expErr; bit expEn; int expPeriod;
    int d1; int d2;
  } vec_t;
  vec_t vecs[8];

  pwm_ramp_sequencer_if #(.W(32)) cmdIf ();

  pwm_ramp_sequencer #(.W(32)) dut (
    .Clk_In         (clk),
    .Reset_In       (rst),
    .cmdIf          (cmdIf),
    .Stop_In        (stop),
    .PWM_Enable_Out (enable),
    .PWM_Period_Out (period),
    .PWM_Duty_Out   (duty),
    .Busy_Out       (busy),
    .At_Target_Out  (atTarget),
    .Done_Out       (done),
    .Err_Out        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tickTo(input int target);
    while (cyc < target) tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic applyStimulus(input int p, input int tgt, input int st);
    checkOutput("readyBeforeCmd", {31'd0, cmdIf.Cmd_Ready_Out}, 32'd1);
    cmdIf.Cmd_Valid_In  = 1'b1;
    cmdIf.Cmd_Period_In = p;
    cmdIf.Cmd_Target_In = tgt;
    cmdIf.Cmd_Step_In   = st;
    tick();
    cmdIf.Cmd_Valid_In  = 1'b0;
  endtask

  task automatic pulseReset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
  endtask

  // Boundaries fall every curP+1 edges counted from the IDLE acceptance edge
  task automatic followSeq(input string name);
    int nb;
    foreach (expSeq[i]) begin
      nb = accEdge + ((cyc - accEdge) / (curP + 1) + 1) * (curP + 1);
      tickTo(nb - 1);
      checkOutput({name, "Pre"}, duty, prevDuty);
      tick();
      checkOutput(name, duty, expSeq[i]);
      prevDuty = expSeq[i];
    end
  endtask

  function automatic void buildRamp(input int d, input int t, input int s);
    expSeq.delete();
    do begin
      if (s == 0)      d = t;
      else if (t >= d) d = (d + s > t) ? t : d + s;
      else             d = (d - s < t) ? t : d - s;
      expSeq.push_back(d);
    end while (d != t);
  endfunction

  function automatic void buildStop(input int d, input int s);
    expSeq.delete();
    while (!(d <= s || s == 0)) begin
      d -= s;
      expSeq.push_back(d);
    end
    expSeq.push_back(0);
  endfunction

  initial begin
    vecs[0] = '{9, 6, 2, 0, 1, 9, 2, 4};
    vecs[1] = '{9, 6, 4, 0, 1, 9, 4, 6};
    vecs[2] = '{9, 6, 0, 0, 1, 9, 6, -1};
    vecs[3] = '{9, 15, 0, 0, 1, 9, 9, -1};
    vecs[4] = '{0, 5, 1, 1, 0, 0, 0, -1};
    vecs[5] = '{9, 15, 4, 0, 1, 9, 4, 8};
    vecs[6] = '{5, 3, 10, 0, 1, 5, 3, -1};
    vecs[7] = '{1, 0, 3, 0, 1, 1, 0, -1};

    rst = 1'b1; stop = 1'b0;
    cmdIf.Cmd_Valid_In = 1'b0; cmdIf.Cmd_Period_In = '0;
    cmdIf.Cmd_Target_In = '0;  cmdIf.Cmd_Step_In = '0;
    #11;
    checkOutput("rstEnable", {31'd0, enable}, 0);
    checkOutput("rstPeriod", period, 0);
    checkOutput("rstDuty", duty, 0);
    checkOutput("rstBusy", {31'd0, busy}, 0);
    checkOutput("rstDone", {31'd0, done}, 0);
    checkOutput("rstErr", {31'd0, err}, 0);
    rst = 1'b0;
    tick();

    // Soft start 9/6/2, re-target down, rejected period change, then soft stop
    applyStimulus(9, 6, 2);
    accEdge = cyc; curP = 9; prevDuty = 0;
    checkOutput("startEnable", {31'd0, enable}, 1);
    checkOutput("startPeriod", period, 9);
    checkOutput("startDuty", duty, 0);
    checkOutput("startBusy", {31'd0, busy}, 1);
    expSeq = '{2, 4, 6};
    followSeq("upA");
    checkOutput("holdA", {31'd0, atTarget}, 1);
    applyStimulus(9, 2, 3);
    checkOutput("downActive", {31'd0, atTarget}, 0);
    expSeq = '{3, 2};
    followSeq("downA");
    checkOutput("holdB", {31'd0, atTarget}, 1);
    applyStimulus(7, 9, 1);
    checkOutput("badPeriodErr", {31'd0, err}, 1);
    checkOutput("badPeriodDuty", duty, 2);
    checkOutput("badPeriodKeep", period, 9);
    tick();
    checkOutput("errPulseEnd", {31'd0, err}, 0);
    checkOutput("stillHold", {31'd0, atTarget}, 1);
    applyStimulus(9, 6, 2);
    expSeq = '{4, 6};
    followSeq("upB");
    #1;
    stop = 1'b1;
    cmdIf.Cmd_Valid_In = 1'b1; cmdIf.Cmd_Period_In = 9;
    cmdIf.Cmd_Target_In = 0;   cmdIf.Cmd_Step_In = 1;
    #1;
    checkOutput("stopBlocksReady", {31'd0, cmdIf.Cmd_Ready_Out}, 0);
    tick();
    cmdIf.Cmd_Valid_In = 1'b0;
    checkOutput("stoppingBusy", {31'd0, busy}, 1);
    checkOutput("stoppingDuty", duty, 6);
    expSeq = '{4, 2, 0};
    followSeq("stopA");
    checkOutput("stopEnable", {31'd0, enable}, 0);
    checkOutput("stopDone", {31'd0, done}, 1);
    checkOutput("stopIdle", {31'd0, busy}, 0);
    checkOutput("stopReadyLow", {31'd0, cmdIf.Cmd_Ready_Out}, 0);
    tick();
    checkOutput("donePulseEnd", {31'd0, done}, 0);
    stop = 1'b0;
    tick();

    // Single-command vectors from IDLE
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].p, vecs[i].tgt, vecs[i].st);
      accEdge = cyc; curP = vecs[i].p; prevDuty = 0;
      checkOutput($sformatf("vec%0dErr", i), {31'd0, err}, {31'd0, vecs[i].expErr});
      checkOutput($sformatf("vec%0dEn", i), {31'd0, enable}, {31'd0, vecs[i].expEn});
      checkOutput($sformatf("vec%0dPeriod", i), period, vecs[i].expPeriod);
      if (vecs[i].expEn) begin
        expSeq = '{vecs[i].d1};
        if (vecs[i].d2 >= 0) expSeq.push_back(vecs[i].d2);
        followSeq($sformatf("vec%0dDuty", i));
        pulseReset();
      end else begin
        tick();
        checkOutput($sformatf("vec%0dErrEnd", i), {31'd0, err}, 0);
        checkOutput($sformatf("vec%0dIdle", i), {31'd0, busy}, 0);
      end
    end

    // Asynchronous reset in the middle of a ramp
    applyStimulus(9, 6, 2);
    accEdge = cyc;
    repeat (12) tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstEnable", {31'd0, enable}, 0);
    checkOutput("midRstDuty", duty, 0);
    checkOutput("midRstPeriod", period, 0);
    checkOutput("midRstBusy", {31'd0, busy}, 0);
    checkOutput("midRstDone", {31'd0, done}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    checkOutput("postRstDone", {31'd0, done}, 0);
    applyStimulus(5, 5, 5);
    accEdge = cyc; curP = 5; prevDuty = 0;
    checkOutput("freshDuty", duty, 0);
    expSeq = '{5};
    followSeq("freshUp");
    checkOutput("freshHold", {31'd0, atTarget}, 1);
    pulseReset();

    // Randomized soft start / soft stop against the sequence model
    for (int n = 0; n < 10; n++) begin
      int p, tgt, s, t, h;
      p   = $urandom_range(1, 12);
      tgt = $urandom_range(0, 20);
      s   = $urandom_range(0, 7);
      t   = (tgt < p) ? tgt : p;
      applyStimulus(p, tgt, s);
      accEdge = cyc; curP = p; prevDuty = 0;
      checkOutput("rndEnable", {31'd0, enable}, 1);
      checkOutput("rndPeriod", period, p);
      buildRamp(0, t, s);
      followSeq("rndUp");
      checkOutput("rndHold", {31'd0, atTarget}, 1);
      h = $urandom_range(0, 2 * p);
      repeat (h) tick();
      stop = 1'b1;
      tick();
      buildStop(t, s);
      prevDuty = t;
      followSeq("rndStop");
      checkOutput("rndStopEnable", {31'd0, enable}, 0);
      checkOutput("rndStopDone", {31'd0, done}, 1);
      stop = 1'b0;
      tick();
      checkOutput("rndDoneEnd", {31'd0, done}, 0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
- Front-end controller for one PWM generator channel.
- Accepts ramp commands over a valid/ready handshake and drives the generator's enable, period and duty inputs.
- Steps duty from its current value toward a target by a fixed step once per PWM period, holds it there, and ramps it back to zero on stop before disabling the channel.
- Gives soft-start and soft-stop without software polling.

Parameters:
- W, 32, width of period/duty/step values in clock cycles (ns at 1 GHz).

Ports:
- Clk_In  in  1  system clock; all logic on rising edge
- Reset_In  in  1  reset, asynchronous, active-high
- Cmd_Valid_In  in  1  command valid
- Cmd_Ready_Out  out  1  command accepted when Valid & Ready at a rising edge
- Cmd_Period_In  in  W  PWM period for this command
- Cmd_Target_In  in  W  target duty
- Cmd_Step_In  in  W  duty increment/decrement per period
- Stop_In  in  1  level; request soft stop
- PWM_Enable_Out  out  1  to generator enable
- PWM_Period_Out  out  W  to generator period
- PWM_Duty_Out  out  W  to generator duty
- Busy_Out  out  1  high in every state except IDLE
- At_Target_Out  out  1  high in HOLD
- Done_Out  out  1  one-cycle pulse when the channel is disabled after a soft stop
- Err_Out  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset: state IDLE; all outputs 0; period counter 0.
- Period tracker: Cnt counts 0..PWM_Period_Out while PWM_Enable_Out = 1, then wraps to 0. Boundary = (Cnt == PWM_Period_Out) & enable. Cnt is held at 0 while disabled. One period is Period+1 clocks.
- Cmd_Ready_Out = (state == IDLE or HOLD) & ~Stop_In. This is combinational and has no dependency on Cmd_Valid_In.
- Target clamp: effective target T = min(Cmd_Target_In, Cmd_Period_In), latched on accept. Step S is latched on accept. S = 0 means "jump": duty goes straight to T at the next boundary.
- Accept in IDLE:
  - Cmd_Period_In = 0: reject, pulse Err_Out, stay in IDLE.
  - Otherwise: latch PWM_Period_Out, set Duty = 0, set Enable = 1, go to RAMP_UP.
  - Enable and Period change in the same cycle, so the generator latches the period on its enable edge.
- Accept in HOLD:
  - Cmd_Period_In != PWM_Period_Out: reject, pulse Err_Out, stay in HOLD. The period can only change through IDLE.
  - Otherwise: latch T and S; go to RAMP_UP if T > Duty, RAMP_DOWN_T if T < Duty, stay in HOLD if equal.
- RAMP_UP, on each boundary: Duty <= min(Duty + S, T), computed with W+1-bit sum, no wrap. When the new Duty equals T, go to HOLD.
- RAMP_DOWN_T, on each boundary: Duty <= max(Duty - S, T), no underflow. When the new Duty equals T, go to HOLD.
- HOLD: Duty constant; At_Target_Out = 1.
- Stop_In = 1 in RAMP_UP, RAMP_DOWN_T or HOLD: go to STOPPING on the next edge, keeping the current Duty. Stop_In in IDLE or STOPPING is ignored.
- STOPPING, on each boundary:
  - If Duty <= S or S == 0: Duty <= 0, Enable <= 0, Cnt <= 0, go to IDLE, Done_Out = 1 for one cycle.
  - Else: Duty <= Duty - S.
- Duty updates only at boundaries. Exception: acceptance from IDLE sets Duty = 0 immediately.
- Simultaneous Stop_In and Cmd_Valid_In: Stop wins and the command is not accepted (Ready is low).
- Reset mid-operation: everything returns to reset values immediately. Enable drops asynchronously and Done_Out is not pulsed.
- Invariant: PWM_Duty_Out <= PWM_Period_Out at all times.

Decomposition:
- Package pwm_seq_pkg holds:
  - state enum: IDLE, RAMP_UP, RAMP_DOWN_T, HOLD, STOPPING (3-bit encoding)
  - W default constant
  - saturating add/sub helper functions
- Sub-module pwm_period_tracker: Cnt register plus Boundary output. It takes Clk_In, Reset_In, enable and period.

Test Plan:
- Period 9, target 6, step 2 from IDLE:
  - Enable and Period = 9 the cycle after accept, Duty = 0.
  - Duty becomes 2, 4, 6 at the boundaries 10 clocks apart.
  - HOLD and At_Target = 1 after the third boundary.
- Period 9, target 6, step 4: Duty 0 → 4 → 6, confirming saturation at target. Step 0: Duty 0 → 6 at the first boundary.
- Target 15, period 9: T clamps to 9. Period 0 command: Err_Out pulses once, state stays IDLE, Enable stays 0.
- HOLD at Duty 6, step 2, assert Stop_In:
  - Duty 4, 2 at successive boundaries.
  - At the next boundary: Duty 0, Enable 0, Done_Out one cycle, IDLE.
  - Ready is low throughout.
- HOLD at period 9, duty 6:
  - New command with period 9, target 2, step 3: Duty 3, then 2, then HOLD.
  - New command with period 7: Err_Out pulses, Duty and period unchanged.
- Assert Reset_In mid-RAMP_UP, between clock edges: all outputs 0 immediately, no Done_Out. After release, a fresh command ramps correctly from Duty 0.
